// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable data width, parity and stop bits, fed by a small input FIFO.
// The host pushes words while ready is high; frames go out back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 transmit,
  output logic                 ready,
  output logic                 overflow,
  output logic                 tx,
  output logic                 busy
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W        = $clog2(DATA_BITS);
  localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
  localparam int unsigned COUNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [COUNT_W-1:0]   count, count_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit;
  state_t               state;

  logic                 push_c, pop_c, baud_last_c, frame_end_c, idle_nxt_c;
  logic [DATA_BITS-1:0] head_c;

  // Pop happens from IDLE or on the final stop clock, so frames chain with no idle gap
  always_comb begin
    push_c      = transmit && ready;
    baud_last_c = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    frame_end_c = (state == S_STOP) && baud_last_c && (bit_idx == IDX_W'(STOP_BITS - 1));
    pop_c       = (count != '0) && ((state == S_IDLE) || frame_end_c);
    idle_nxt_c  = ((state == S_IDLE) || frame_end_c) && !pop_c;
    head_c      = mem[rd_ptr];
    count_nxt   = count;
    if (push_c && !pop_c) begin
      count_nxt = count + COUNT_W'(1);
    end else if (!push_c && pop_c) begin
      count_nxt = count - COUNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready    <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
      tx       <= 1'b1;
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      overflow <= transmit && !ready;
      count    <= count_nxt;
      ready    <= (count_nxt != COUNT_W'(FIFO_DEPTH));
      busy     <= !idle_nxt_c || (count_nxt != '0);
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end

      unique case (state)
        S_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop_c) begin
            shreg   <= head_c;
            par_bit <= (^head_c) ^ (PARITY == 1);
            tx      <= 1'b0;
            state   <= S_START;
          end
        end
        S_START: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= shreg[0];
            shreg    <= {1'b0, shreg[DATA_BITS-1:1]};
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PARITY;
              end else begin
                tx    <= 1'b1;
                state <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
              tx      <= shreg[0];
              shreg   <= {1'b0, shreg[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_PARITY: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            state    <= S_STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (baud_last_c) begin
            baud_cnt <= '0;
            if (frame_end_c) begin
              bit_idx <= '0;
              if (pop_c) begin
                shreg   <= head_c;
                par_bit <= (^head_c) ^ (PARITY == 1);
                tx      <= 1'b0;
                state   <= S_START;
              end else begin
                state <= S_IDLE;
              end
            end else begin
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations run side by side, each checked every cycle
// against a frame-level model (queue of words + timer into a precomputed bit list).
module tb_uart_tx_fifo;

  localparam int CPB   = 10;
  localparam int DEPTH = 4;
  localparam int NCFG  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trans_v [NCFG];
  logic [8:0] din_v   [NCFG];
  logic       tx_v    [NCFG];
  logic       busy_v  [NCFG];
  logic       ready_v [NCFG];
  logic       ovf_v   [NCFG];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cfg%0d t=%0t got %b want %b", nm, g, $time, act, exp);
  endtask

  // cfg0: 8N1, cfg1: 8E1, cfg2: 8O1, cfg3: 7N2
  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    localparam int DBG  = (g == 3) ? 7 : 8;
    localparam int PARG = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
    localparam int SBG  = (g == 3) ? 2 : 1;
    localparam int FL   = (1 + DBG + ((PARG != 0) ? 1 : 0) + SBG) * CPB;

    uart_tx_fifo #(
      .CLOCK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(DBG),
      .PARITY(PARG), .STOP_BITS(SBG), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .data_in(din_v[g][DBG-1:0]), .transmit(trans_v[g]),
      .ready(ready_v[g]), .overflow(ovf_v[g]), .tx(tx_v[g]), .busy(busy_v[g])
    );

    int q[$];
    bit act = 1'b0;
    int t = 0;
    bit fb[16];
    bit m_tx = 1'b1, m_busy = 1'b0, m_ready = 1'b1, m_ovf = 1'b0;

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        act = 1'b0; t = 0;
        m_tx = 1'b1; m_busy = 1'b0; m_ready = 1'b1; m_ovf = 1'b0;
      end else begin
        bit full, psh;
        int w, ones;
        full  = (q.size() == DEPTH);
        psh   = trans_v[g] && !full;
        m_ovf = trans_v[g] && full;
        if (act) begin
          t++;
          if (t == FL) act = 1'b0;
        end
        if (!act && q.size() > 0) begin
          w = q.pop_front();
          for (int j = 0; j < 16; j++) fb[j] = 1'b1;
          fb[0] = 1'b0;
          ones = 0;
          for (int j = 0; j < DBG; j++) begin
            fb[1+j] = ((w >> j) & 1) != 0;
            if (fb[1+j]) ones++;
          end
          if (PARG == 2) fb[1+DBG] = (ones % 2) == 1;
          if (PARG == 1) fb[1+DBG] = (ones % 2) == 0;
          act = 1'b1; t = 0;
        end
        if (psh) q.push_back(int'(din_v[g]) & ((1 << DBG) - 1));
        m_tx    = act ? fb[t / CPB] : 1'b1;
        m_busy  = act || (q.size() != 0);
        m_ready = (q.size() != DEPTH);
      end
    end

    always @(negedge clk) begin
      chk("tx", g, tx_v[g], m_tx);
      chk("busy", g, busy_v[g], m_busy);
      chk("ready", g, ready_v[g], m_ready);
      chk("overflow", g, ovf_v[g], m_ovf);
    end
  end

  logic [15:0] pats [NCFG];
  int          flen [NCFG];

  initial begin
    bit all_idle;
    for (int g = 0; g < NCFG; g++) begin
      trans_v[g] = 1'b0;
      din_v[g]   = '0;
    end
    pats[0] = 16'h02AA; flen[0] = 100;   // 0x55, 8N1
    pats[1] = 16'h0546; flen[1] = 110;   // 0xA3, even parity 0
    pats[2] = 16'h0746; flen[2] = 110;   // 0xA3, odd parity 1
    pats[3] = 16'h0382; flen[3] = 100;   // 0x41, 7 bits, 2 stop

    repeat (3) @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      chk("rst_tx", g, tx_v[g], 1'b1);
      chk("rst_busy", g, busy_v[g], 1'b0);
      chk("rst_ready", g, ready_v[g], 1'b1);
      chk("rst_ovf", g, ovf_v[g], 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single frames on every configuration, literal waveform checks
    din_v[0] = 9'h055; din_v[1] = 9'h0A3; din_v[2] = 9'h0A3; din_v[3] = 9'h041;
    for (int g = 0; g < NCFG; g++) trans_v[g] = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NCFG; g++) begin
      trans_v[g] = 1'b0;
      chk("lat_tx_high", g, tx_v[g], 1'b1);
      chk("lat_busy", g, busy_v[g], 1'b1);
    end
    for (int i = 1; i <= 112; i++) begin
      @(negedge clk);
      for (int g = 0; g < NCFG; g++) begin
        if (i <= flen[g] && ((i - 1) % CPB) == 5) chk("bit", g, tx_v[g], pats[g][(i-1)/CPB]);
        if (i == 1) chk("start_fall", g, tx_v[g], 1'b0);
        if (i == flen[g]) chk("busy_last", g, busy_v[g], 1'b1);
        if (i == flen[g] + 1) begin
          chk("busy_end", g, busy_v[g], 1'b0);
          chk("idle_tx", g, tx_v[g], 1'b1);
        end
      end
    end

    // Three back-to-back words: 300 clocks of continuous traffic
    trans_v[0] = 1'b1; din_v[0] = 9'h001;
    @(negedge clk); din_v[0] = 9'h002;
    @(negedge clk); din_v[0] = 9'h003;
    @(negedge clk); trans_v[0] = 1'b0;
    for (int i = 3; i <= 301; i++) begin
      @(negedge clk);
      if (i == 300) chk("b2b_busy_last", 0, busy_v[0], 1'b1);
      if (i == 301) chk("b2b_busy_end", 0, busy_v[0], 1'b0);
    end
    repeat (5) @(negedge clk);

    // Six pushes into a depth-4 FIFO: fifth fills it, sixth overflows
    for (int k = 0; k < 6; k++) begin
      trans_v[0] = 1'b1;
      din_v[0]   = 9'($urandom_range(0, 255));
      @(negedge clk);
      if (k == 4) chk("full_ready", 0, ready_v[0], 1'b0);
      if (k == 5) chk("ovf_pulse", 0, ovf_v[0], 1'b1);
    end
    trans_v[0] = 1'b0;
    @(negedge clk);
    chk("ovf_clear", 0, ovf_v[0], 1'b0);
    all_idle = 1'b0;
    for (int c = 0; c < 700 && !all_idle; c++) begin
      @(negedge clk);
      all_idle = !busy_v[0];
    end
    chk("drain5", 0, busy_v[0], 1'b0);
    repeat (3) @(negedge clk);

    // Reset during data bit 3 with two words still queued
    trans_v[0] = 1'b1; din_v[0] = 9'h0C6;
    @(negedge clk); din_v[0] = 9'h039;
    @(negedge clk); din_v[0] = 9'h0F0;
    @(negedge clk); trans_v[0] = 1'b0;
    repeat (43) @(negedge clk);
    chk("pre_rst_busy", 0, busy_v[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", 0, tx_v[0], 1'b1);
    chk("mid_rst_busy", 0, busy_v[0], 1'b0);
    chk("mid_rst_ready", 0, ready_v[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    chk("post_rst_tx", 0, tx_v[0], 1'b1);
    chk("post_rst_busy", 0, busy_v[0], 1'b0);

    // Random traffic, alternating sparse and bursty phases
    for (int c = 0; c < 4000; c++) begin
      for (int g = 0; g < NCFG; g++) begin
        trans_v[g] = ((c / 500) % 2 == 1) ? ($urandom_range(0, 15) < 12)
                                          : ($urandom_range(0, 15) < 1);
        din_v[g]   = 9'($urandom_range(0, 511));
      end
      @(negedge clk);
    end
    for (int g = 0; g < NCFG; g++) trans_v[g] = 1'b0;
    all_idle = 1'b0;
    for (int c = 0; c < 3000 && !all_idle; c++) begin
      @(negedge clk);
      all_idle = 1'b1;
      for (int g = 0; g < NCFG; g++) if (busy_v[g]) all_idle = 1'b0;
    end
    for (int g = 0; g < NCFG; g++) chk("final_drain", g, busy_v[g], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
